bit8_manipulator: RTL and testbench
===================================

// Module: bit8_manipulator
// PURPOSE
//  Single-bit shift/rotate unit for the ALU datapath. Shifts or rotates operand A one position
//  left or right, combinationally on Out, and also captures the result in a clocked output stage.
//  Sits beside the adder/logic units; the ALU result mux selects Out, the registered copy feeds pipelined users.
// PARAMETERS
//  WIDTH      8   operand/result width in bits (>=2); all widths below scale with it
// PORTS
//  clk        in   1      clock, rising-edge active
//  rst_n      in   1      reset, asynchronous assert, active-low
//  A          in   WIDTH  operand
//  direction  in   1      0 = left, 1 = right
//  rotate     in   1      0 = logical shift (zero fill), 1 = rotate (wrap)
//  en         in   1      capture strobe for registered stage
//  Out        out  WIDTH  combinational result
//  out_q      out  WIDTH  registered result
//  valid_q    out  1      registered: out_q holds a captured result
//  carry_q    out  1      registered: bit shifted/rotated out
//  zero_q     out  1      registered: captured result == 0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Combinational path (no clock dependency; settles within the same delta, independent of rst_n/en):
//   - dir=0 rot=0: Out = A << 1 (LSB <= 0, MSB discarded)
//   - dir=1 rot=0: Out = A >> 1 (MSB <= 0, LSB discarded)
//   - dir=0 rot=1: Out = {A[W-2:0], A[W-1]}
//   - dir=1 rot=1: Out = {A[0], A[W-1:1]}
//   - No X on Out for known inputs; any X/Z on A propagates only to the affected bit positions.
//  carry (internal): dir=0 -> A[W-1]; dir=1 -> A[0]; same rule for shift and rotate.
//  Registered stage:
//   - rst_n low (any time, async): out_q=0, valid_q=0, carry_q=0, zero_q=0; holds while low.
//   - rising clk with en=1: out_q<=Out, carry_q<=carry, zero_q<=(Out==0), valid_q<=1. Latency 1 cycle.
//   - rising clk with en=0: all registers hold (valid_q stays 1 once set until reset).
//   - Reset deassertion takes effect on next edge; reset mid-operation discards pending capture.
//  Boundary: A=0 -> Out=0 all modes; all-ones shift fills 0 at vacated end; rotate of all-ones = all-ones.
// CONFIGURATION
//  MANIP_FLAGS_EN defined: carry_q and zero_q function as above.
//  MANIP_FLAGS_EN undefined: carry_q and zero_q tied to 0 (no flops); Out, out_q, valid_q unchanged.
// TESTING
//  A=8'hFF dir=0 rot=0 -> Out=8'hFE; dir=1 -> Out=8'h7F.
//  A=8'hAA dir=0 rot=0 -> Out=8'h54; dir=1 rot=0 -> Out=8'h55.
//  A=8'h01 dir=1 rot=1 -> Out=8'h80; A=8'h80 dir=0 rot=1 -> Out=8'h01; A=8'hB3 dir=0 rot=1 -> 8'h67.
//  A=8'h80 dir=0 rot=0 en=1, clk edge -> out_q=8'h00, zero_q=1, carry_q=1, valid_q=1 (flags only if MANIP_FLAGS_EN).
//  en=0 for 3 edges with A changing -> out_q/flags hold; Out tracks A combinationally.
//  rst_n low between edges -> all registered outputs 0 immediately; Out unaffected.
//  Random: 20+ vectors, all 4 dir/rot combos, Out compared to behavioural model with !==.

Source files
------------

// File: rtl/bit8_manipulator_if.sv
// Operand/control and result bundle for the single-bit shift/rotate unit.
// The ALU side drives the master modport; bit8_manipulator consumes the slave modport.
interface bit8_manipulator_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic             direction;
    logic             rotate;
    logic             en;
    logic [WIDTH-1:0] Out;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             carry_q;
    logic             zero_q;

    modport master (
        output A, direction, rotate, en,
        input  Out, out_q, valid_q, carry_q, zero_q
    );

    modport slave (
        input  A, direction, rotate, en,
        output Out, out_q, valid_q, carry_q, zero_q
    );
endinterface

// File: rtl/bit8_manipulator.sv
// Single-bit shift/rotate unit: combinational result on Out plus an en-gated registered copy.
// Optional MANIP_FLAGS_EN adds registered carry/zero flags; otherwise those outputs are tied low.
module bit8_manipulator #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bit8_manipulator_if.slave bus
);

    // Pure bit selects so an X on one A bit only lands in the one result bit it feeds.
    function automatic logic [WIDTH-1:0] manip(input logic [WIDTH-1:0] a,
                                               input logic             dir,
                                               input logic             rot);
        case ({dir, rot})
            2'b00:   return {a[WIDTH-2:0], 1'b0};
            2'b01:   return {a[WIDTH-2:0], a[WIDTH-1]};
            2'b10:   return {1'b0, a[WIDTH-1:1]};
            2'b11:   return {a[0], a[WIDTH-1:1]};
            default: return 'x;
        endcase
    endfunction

    function automatic logic carry_out(input logic [WIDTH-1:0] a, input logic dir);
        return dir ? a[0] : a[WIDTH-1];
    endfunction

    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] res_d, res_q;
    logic             vld_d, vld_q;

    assign res_c   = manip(bus.A, bus.direction, bus.rotate);
    assign bus.Out = res_c;

    always_comb begin
        res_d = res_q;
        vld_d = vld_q;
        if (bus.en) begin
            res_d = res_c;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign bus.out_q   = res_q;
    assign bus.valid_q = vld_q;

`ifdef MANIP_FLAGS_EN
    logic carry_d, carry_q;
    logic zero_d, zero_q;

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (bus.en) begin
            carry_d = carry_out(bus.A, bus.direction);
            zero_d  = (res_c == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.carry_q = carry_q;
    assign bus.zero_q  = zero_q;
`else
    assign bus.carry_q = 1'b0;
    assign bus.zero_q  = 1'b0;
`endif

endmodule

// File: tb/tb_bit8_manipulator.sv
// Self-checking bench for bit8_manipulator: directed vectors, capture/hold, async reset, random sweep.
// Flag expectations follow MANIP_FLAGS_EN the same way the design does.
module tb_bit8_manipulator;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Expected registered state (reference model)
    logic [W-1:0] m_out;
    logic         m_vld, m_carry, m_zero;

    bit8_manipulator_if #(.WIDTH(W)) bus ();

    bit8_manipulator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic view: shifting left is doubling, right is halving.
    function automatic logic [W-1:0] ref_out(input int a, input logic dir, input logic rot);
        int r;
        if (!dir) r = ((a * 2) % 256) + (rot ? (a / 128) : 0);
        else      r = (a / 2) + (rot ? ((a % 2) * 128) : 0);
        return r[W-1:0];
    endfunction

    function automatic logic ref_carry(input int a, input logic dir);
        return dir ? ((a % 2) == 1) : (a >= 128);
    endfunction

    function automatic logic flag_exp(input logic f);
`ifdef MANIP_FLAGS_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_capture(input int a, input logic dir, input logic rot);
        m_out   = ref_out(a, dir, rot);
        m_vld   = 1'b1;
        m_carry = ref_carry(a, dir);
        m_zero  = (ref_out(a, dir, rot) == 0);
    endtask

    task automatic model_reset();
        m_out = '0; m_vld = 1'b0; m_carry = 1'b0; m_zero = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.A = 8'h5A; bus.direction = 1'b0; bus.rotate = 1'b0; bus.en = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_q !== 8'h00) begin errors++; $display("FAIL reset_out_q got %h exp 00", bus.out_q); end
        checks++;
        if (bus.valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_q); end
        checks++;
        if ({bus.carry_q, bus.zero_q} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b exp 00", {bus.carry_q, bus.zero_q});
        end
        checks++;
        if (bus.Out !== 8'hB4) begin errors++; $display("FAIL reset_comb got %h exp b4", bus.Out); end
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [7];
        logic         vd [7];
        logic         vr [7];
        logic [W-1:0] ve [7];
        va = '{8'hFF, 8'hFF, 8'hAA, 8'hAA, 8'h01, 8'h80, 8'hB3};
        vd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ve = '{8'hFE, 8'h7F, 8'h54, 8'h55, 8'h80, 8'h01, 8'h67};
        for (int i = 0; i < 7; i++) begin
            bus.A = va[i]; bus.direction = vd[i]; bus.rotate = vr[i];
            #1;
            checks++;
            if (bus.Out !== ve[i]) begin
                errors++; $display("FAIL directed_%0d A=%h got %h exp %h", i, va[i], bus.Out, ve[i]);
            end
        end
        // Boundary: zero in every mode, all-ones rotate stays all-ones
        for (int m = 0; m < 4; m++) begin
            bus.A = 8'h00; bus.direction = m[1]; bus.rotate = m[0];
            #1;
            checks++;
            if (bus.Out !== 8'h00) begin errors++; $display("FAIL zero_mode%0d got %h exp 00", m, bus.Out); end
            bus.A = 8'hFF;
            #1;
            checks++;
            if (bus.Out !== ref_out(255, m[1], m[0])) begin
                errors++; $display("FAIL ones_mode%0d got %h exp %h", m, bus.Out, ref_out(255, m[1], m[0]));
            end
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        bus.A = 8'h80; bus.direction = 1'b0; bus.rotate = 1'b0; bus.en = 1'b1;
        model_capture(128, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.out_q !== 8'h00) begin errors++; $display("FAIL cap_out_q got %h exp 00", bus.out_q); end
        checks++;
        if (bus.valid_q !== 1'b1) begin errors++; $display("FAIL cap_valid got %b exp 1", bus.valid_q); end
        checks++;
        if (bus.zero_q !== flag_exp(1'b1)) begin
            errors++; $display("FAIL cap_zero got %b exp %b", bus.zero_q, flag_exp(1'b1));
        end
        checks++;
        if (bus.carry_q !== flag_exp(1'b1)) begin
            errors++; $display("FAIL cap_carry got %b exp %b", bus.carry_q, flag_exp(1'b1));
        end
    endtask

    task automatic test_hold();
        int a;
        @(negedge clk);
        bus.A = 8'hAB; bus.direction = 1'b1; bus.rotate = 1'b1; bus.en = 1'b1;
        model_capture(171, 1'b1, 1'b1);
        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom_range(0, 255);
            bus.A = a[W-1:0];
            #1;
            checks++;
            if (bus.Out !== ref_out(a, 1'b1, 1'b1)) begin
                errors++; $display("FAIL hold_comb_%0d got %h exp %h", i, bus.Out, ref_out(a, 1'b1, 1'b1));
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.out_q, bus.valid_q, bus.carry_q, bus.zero_q} !==
                {m_out, m_vld, flag_exp(m_carry), flag_exp(m_zero)}) begin
                errors++;
                $display("FAIL hold_%0d got %h/%b%b%b exp %h/%b%b%b", i, bus.out_q, bus.valid_q,
                         bus.carry_q, bus.zero_q, m_out, m_vld, flag_exp(m_carry), flag_exp(m_zero));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.A = 8'h41; bus.direction = 1'b1; bus.rotate = 1'b0; bus.en = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.out_q, bus.valid_q, bus.carry_q, bus.zero_q} !== 11'd0) begin
            errors++; $display("FAIL async_rst got %h/%b%b%b exp 00/000", bus.out_q, bus.valid_q,
                               bus.carry_q, bus.zero_q);
        end
        checks++;
        if (bus.Out !== 8'h20) begin errors++; $display("FAIL async_rst_comb got %h exp 20", bus.Out); end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_q, bus.valid_q} !== 9'd0) begin
            errors++; $display("FAIL rst_held got %h/%b exp 00/0", bus.out_q, bus.valid_q);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (bus.valid_q !== 1'b0) begin errors++; $display("FAIL rst_release got %b exp 0", bus.valid_q); end
        @(posedge clk); #1;
        model_capture(65, 1'b1, 1'b0);
        checks++;
        if ({bus.out_q, bus.valid_q, bus.carry_q} !== {m_out, m_vld, flag_exp(m_carry)}) begin
            errors++; $display("FAIL post_rst_cap got %h/%b%b exp %h/%b%b", bus.out_q, bus.valid_q,
                               bus.carry_q, m_out, m_vld, flag_exp(m_carry));
        end
    endtask

    task automatic test_random();
        int   a;
        logic d, r, e;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a = $urandom_range(0, 255);
            d = i[1]; r = i[0];
            e = ($urandom_range(0, 3) != 0);
            bus.A = a[W-1:0]; bus.direction = d; bus.rotate = r; bus.en = e;
            #1;
            checks++;
            if (bus.Out !== ref_out(a, d, r)) begin
                errors++; $display("FAIL rand_comb_%0d A=%h d=%b r=%b got %h exp %h", i, a[W-1:0], d, r,
                                   bus.Out, ref_out(a, d, r));
            end
            if (e) model_capture(a, d, r);
            @(posedge clk); #1;
            checks++;
            if ({bus.out_q, bus.valid_q, bus.carry_q, bus.zero_q} !==
                {m_out, m_vld, flag_exp(m_carry), flag_exp(m_zero)}) begin
                errors++;
                $display("FAIL rand_reg_%0d got %h/%b%b%b exp %h/%b%b%b", i, bus.out_q, bus.valid_q,
                         bus.carry_q, bus.zero_q, m_out, m_vld, flag_exp(m_carry), flag_exp(m_zero));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] seq [4];
        seq = '{8'h01, 8'h81, 8'h00, 8'h7E};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.A = seq[i]; bus.direction = 1'b0; bus.rotate = 1'b1; bus.en = 1'b1;
            model_capture(int'(seq[i]), 1'b0, 1'b1);
            @(posedge clk); #1;
            checks++;
            if ({bus.out_q, bus.carry_q, bus.zero_q} !== {m_out, flag_exp(m_carry), flag_exp(m_zero)}) begin
                errors++; $display("FAIL b2b_%0d got %h/%b%b exp %h/%b%b", i, bus.out_q, bus.carry_q,
                                   bus.zero_q, m_out, flag_exp(m_carry), flag_exp(m_zero));
            end
        end
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_capture();
        test_hold();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule
